dmem_responder: RTL and testbench

//  Data-memory responder for the pipelined CPU's MEM-stage load/store port.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int BE_W      = 4;
  localparam int LAT_CNT_W = 4;

  // A request errors when it is not word aligned or falls beyond the storage.
  function automatic logic is_err(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes, registered read data and synchronous clear.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              acc_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  assign rdata_o = rdata_q;

  // Clear everything on reset; otherwise write enabled lanes and capture the
  // response word. Read data holds between accesses so the response is stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < 2**ADDR_W; w++) mem_q[w] <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_en_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem_q[word_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      if (acc_i) rdata_q <= rd_en_i ? mem_q[word_i] : '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder with programmable access latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [31:0]       REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [BE_W-1:0]   REQ_BE,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR
);

  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);

  logic [1:0]           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q;
  logic [31:0]          addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [BE_W-1:0]      be_q;
  logic                 rsp_err_q;

  logic                 accept;
  logic                 access;
  logic                 acc_we;
  logic [31:0]          acc_addr;
  logic [DATA_W-1:0]    acc_wdata;
  logic [BE_W-1:0]      acc_be;
  logic                 acc_err;

  assign REQ_READY = (state_q == S_IDLE);
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_ERR   = rsp_err_q;
  assign accept    = REQ_VALID && REQ_READY;

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage access on the edge entering RESP. With single-cycle latency that
  // edge is the accept edge, so the live request is used instead of the latch.
  always_comb begin
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == S_IDLE) begin
      access    = accept && (LATENCY == 1);
      acc_we    = REQ_WE;
      acc_addr  = REQ_ADDR;
      acc_wdata = REQ_WDATA;
      acc_be    = REQ_BE;
    end else if (state_q == S_WAIT) begin
      access = (cnt_q == LAT_CNT_W'(1));
    end
    acc_err = is_err(acc_addr, ADDR_W);
  end

  // FSM, counter and response error flag.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) rsp_err_q <= acc_err;
    end
  end

  // Request latch; the caller may change its inputs after acceptance.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= REQ_WE;
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WDATA;
      be_q    <= REQ_BE;
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .acc_i   (access),
    .wr_en_i (access && acc_we && !acc_err),
    .rd_en_i (access && !acc_we && !acc_err),
    .word_i  (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (RSP_RDATA)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table, reset corner cases, random
// stream against a word model with a response scoreboard.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t        tbl [14];
  exp_t        sb_q [$];
  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(3)) dut0 (
    .CLOCK(clk), .RESET(rst[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_WE(req_we[0]), .REQ_ADDR(req_addr[0]), .REQ_WDATA(req_wdata[0]), .REQ_BE(req_be[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_RDATA(rsp_rdata[0]), .RSP_ERR(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) dut1 (
    .CLOCK(clk), .RESET(rst[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_WE(req_we[1]), .REQ_ADDR(req_addr[1]), .REQ_WDATA(req_wdata[1]), .REQ_BE(req_be[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_RDATA(rsp_rdata[1]), .RSP_ERR(rsp_err[1])
  );

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                              logic [31:0] rdata, logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete transaction: accept, measure latency, hold the response for
  // 'hold' cycles of backpressure, then consume it and confirm return to IDLE.
  task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input string tag);
    int n;
    @(negedge clk);
    check({tag, " req_ready_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be; rsp_ready[d] = 1'b0;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " rdata"}, rsp_rdata[d], exp_rdata);
    check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold_valid"}, 32'(rsp_valid[d]), 32'd1);
      check({tag, " hold_req_ready"}, 32'(req_ready[d]), 32'd0);
      check({tag, " hold_rdata"}, rsp_rdata[d], exp_rdata);
      check({tag, " hold_err"}, 32'(rsp_err[d]), 32'(exp_err));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check({tag, " done_valid"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, " done_req_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_bad;
    logic        we, err;
    logic [31:0] addr, wdata, w;
    logic [3:0]  be;
    int          word, cyc;
    bit          done;
    exp_t        e, got;

    tbl[0]  = mk(1'b0, 32'h0000_0010, 32'h0,          4'hF, 32'h0000_0000, 1'b0);
    tbl[1]  = mk(1'b1, 32'h0000_0020, 32'hDEAD_BEEF,  4'hF, 32'h0000_0000, 1'b0);
    tbl[2]  = mk(1'b1, 32'h0000_0020, 32'h0000_00AA,  4'h1, 32'h0000_0000, 1'b0);
    tbl[3]  = mk(1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'hDEAD_BEAA, 1'b0);
    tbl[4]  = mk(1'b0, 32'h0000_0022, 32'h0,          4'hF, 32'h0000_0000, 1'b1);
    tbl[5]  = mk(1'b1, 32'h0000_1000, 32'h5555_5555,  4'hF, 32'h0000_0000, 1'b1);
    tbl[6]  = mk(1'b0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0000, 1'b0);
    tbl[7]  = mk(1'b1, 32'h0000_0024, 32'h1122_3344,  4'hA, 32'h0000_0000, 1'b0);
    tbl[8]  = mk(1'b0, 32'h0000_0024, 32'h0,          4'hF, 32'h1100_3300, 1'b0);
    tbl[9]  = mk(1'b1, 32'h0000_0024, 32'hFFFF_FFFF,  4'h0, 32'h0000_0000, 1'b0);
    tbl[10] = mk(1'b0, 32'h0000_0024, 32'h0,          4'hF, 32'h1100_3300, 1'b0);
    tbl[11] = mk(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D,  4'hF, 32'h0000_0000, 1'b0);
    tbl[12] = mk(1'b0, 32'h0000_0FFC, 32'h0,          4'hF, 32'hCAFE_F00D, 1'b0);
    tbl[13] = mk(1'b0, 32'h8000_0000, 32'h0,          4'hF, 32'h0000_0000, 1'b1);

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d req_ready", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset%0d rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset%0d rsp_err", d), 32'(rsp_err[d]), 32'd0);
      check($sformatf("reset%0d rsp_rdata", d), rsp_rdata[d], 32'd0);
    end

    // Directed vector table on the three-cycle instance.
    for (int i = 0; i < 14; i++)
      do_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1,
             tbl[i].rdata, tbl[i].err, 3, $sformatf("vec%0d", i));

    // Extended backpressure on a load.
    do_txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 5, 32'hDEAD_BEAA, 1'b0, 3, "backpressure");

    // Reset during WAIT of a store discards it and clears storage.
    do_txn(0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 3, "rst_pre_store");
    do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0, 3, "rst_pre_load");
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h40;
    req_wdata[0] = 32'hFFFF_FFFF; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check("rst_wait rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_wait req_ready", 32'(req_ready[0]), 32'd1);
    n_bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) n_bad++;
    end
    check("rst_wait no_response", 32'(n_bad), 32'd0);
    do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'h0, 1'b0, 3, "rst_post_load");

    // Reset coinciding with an acceptable request wins: no transaction.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h40; rst[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; rst[0] = 1'b0;
    n_bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid[0] || !req_ready[0]) n_bad++;
    end
    check("rst_vs_accept idle", 32'(n_bad), 32'd0);

    // Single-cycle latency instance, reset racing a response handshake.
    do_txn(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 1, "l1_store");
    do_txn(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0, 1, "l1_load");
    do_txn(1, 1'b0, 32'h0000_0041, 32'h0, 4'hF, 0, 32'h0, 1'b1, 1, "l1_misaligned");
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h40;
    req_wdata[1] = 32'hFFFF_FFFF; req_be[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("l1_accept rsp_valid", 32'(rsp_valid[1]), 32'd1);
    rsp_ready[1] = 1'b1; rst[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0; rst[1] = 1'b0;
    check("l1_rst rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("l1_rst req_ready", 32'(req_ready[1]), 32'd1);
    do_txn(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1, "l1_post_load");

    // Random stream on the three-cycle instance; storage was cleared above.
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    for (int k = 0; k < 1500; k++) begin
      we    = 1'($urandom_range(0, 1));
      word  = $urandom_range(0, 15);
      addr  = 32'(word) << 2;
      case ($urandom_range(0, 19))
        0, 1:    addr[1:0] = 2'($urandom_range(1, 3));
        2:       addr = addr | (32'h1 << $urandom_range(12, 31));
        default: ;
      endcase
      wdata = $urandom;
      be    = 4'($urandom);
      err   = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
      if (we && !err) begin
        w = ref_mem[word];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[word] = w;
      end
      e.rdata = (!we && !err) ? ref_mem[word] : 32'h0;
      e.err   = err;
      sb_q.push_back(e);

      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = we; req_addr[0] = addr;
      req_wdata[0] = wdata; req_be[0] = be;
      rsp_ready[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      req_valid[0] = 1'b0; req_wdata[0] = $urandom; req_addr[0] = $urandom;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 60) begin
        rsp_ready[0] = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (rsp_valid[0] && rsp_ready[0]) begin
          got = sb_q.pop_front();
          check($sformatf("rand%0d rdata", k), rsp_rdata[0], got.rdata);
          check($sformatf("rand%0d err", k), 32'(rsp_err[0]), 32'(got.err));
          done = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL rand%0d response actual=timeout required=handshake", k);
        sb_q.delete();
      end
    end
    rsp_ready[0] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
